ifetch_unit: RTL and testbench

Instruction fetch front end for the RV32 core. It owns the fetch address and issues word reads to instruction memory over a req/gnt/rvalid handshake, with at most one read outstanding. Returned instructions go into a small FIFO and are handed to decode with valid/ready. A taken branch or jump (`redirect_i`, driven from the ALU target path) flushes everything in flight and restarts fetch at the new target.

---
 rtl/ifetch_unit.sv | 122 ++++++++++++
 tb/tb_ifetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32 instruction fetch front end.
// One read in flight, small instruction FIFO, redirect flush.
module ifetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] instr_pc_four_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;

  logic accept;
  logic push;
  logic pop;

  assign mem_req_o  = (state == REQ) && (count < CW'(DEPTH));
  assign mem_addr_o = fetch_pc;
  assign accept     = mem_req_o && mem_gnt_i;
  assign push       = (state == WAIT) && mem_rvalid_i;
  assign pop        = instr_valid_o && instr_ready_i;

  assign instr_valid_o   = (count != '0);
  assign instr_o         = fifo_instr[rptr];
  assign instr_pc_o      = fifo_pc[rptr];
  assign instr_pc_four_o = fifo_pc[rptr] + 32'd4;

  // Fetch FSM and fetch address; a redirect overrides every other event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      unique case (state)
        IDLE:  state <= REQ;
        REQ:   state <= accept ? DRAIN : REQ;
        WAIT,
        DRAIN: state <= mem_rvalid_i ? REQ : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT,
        DRAIN: begin
          if (mem_rvalid_i) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Instruction FIFO: push returned words, pop on decode handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_instr[wptr] <= mem_rdata_i;
        fifo_pc[wptr]    <= req_pc;
        wptr             <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit.
// Two instances: RESET_PC 0x100 main, 0xFFFF_FFFC for wrap.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] rpc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_four;

  logic        rst_b;
  logic        req_b;
  logic [31:0] addr_b;
  logic        rv_b;
  logic [31:0] ad_b;
  logic        valid_b;
  logic [31:0] instr_b;
  logic [31:0] pc_b;
  logic [31:0] pc4_b;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          lat;
  logic        gnt_en;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .redirect_i      (redirect),
    .redirect_pc_i   (rpc),
    .mem_req_o       (mem_req),
    .mem_addr_o      (mem_addr),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_pc_four_o (instr_pc_four)
  );

  ifetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk_i           (clk),
    .rst_i           (rst_b),
    .redirect_i      (1'b0),
    .redirect_pc_i   (32'h0),
    .mem_req_o       (req_b),
    .mem_addr_o      (addr_b),
    .mem_gnt_i       (1'b1),
    .mem_rvalid_i    (rv_b),
    .mem_rdata_i     (mk(ad_b)),
    .instr_valid_o   (valid_b),
    .instr_ready_i   (1'b0),
    .instr_o         (instr_b),
    .instr_pc_o      (pc_b),
    .instr_pc_four_o (pc4_b)
  );

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'hA5C3_0F69;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // memory model A: variable grant and rvalid latency
  assign mem_gnt    = gnt_en;
  assign mem_rvalid = pend && (cnt == 0);
  assign mem_rdata  = mem_rvalid ? mk(paddr) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= 32'h0;
    end else begin
      if (mem_rvalid) pend <= 1'b0;
      if (mem_req && mem_gnt) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= mem_addr;
      end else if (pend && cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  // memory model B: grant tied, one-cycle rvalid
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rv_b <= 1'b0;
      ad_b <= 32'h0;
    end else begin
      rv_b <= req_b;
      ad_b <= addr_b;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: compare delivered instructions against expected pcs
  always @(negedge clk) begin
    if (!rst && !redirect && instr_valid && instr_ready &&
        exp_q.size() != 0) begin
      sb_e = exp_q.pop_front();
      chk("sb_pc", instr_pc, sb_e);
      chk("sb_ins", instr, mk(sb_e));
      chk("sb_pc4", instr_pc_four, sb_e + 32'd4);
    end
    if (!rst && mem_req && mem_gnt) n_acc <= n_acc + 1;
  end

  task automatic wait_acc(input string tag, input logic [31:0] exp,
                          input bit use_exp, output int c);
    bit found = 0;
    c = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) begin
        found = 1;
        c = cyc;
        if (use_exp) chk(tag, mem_addr, exp);
      end
    end
    if (!found || !use_exp) chk({tag, "_seen"}, 32'(found), 32'h1);
  endtask

  task automatic wait_q_empty(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_sig(input string tag, input bit rv);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (rv ? mem_rvalid : mem_req) found = 1;
    end
    chk(tag, 32'(found), 32'h1);
  endtask

  initial begin
    int r, c0, c1, c2, a0, nb;
    logic [31:0] a, s, ba1, ba2;
    rst = 1'b1;
    rst_b = 1'b1;
    redirect = 1'b0;
    rpc = 32'h0;
    instr_ready = 1'b1;
    gnt_en = 1'b1;
    lat = 1;

    // reset values
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h100);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_pc4", instr_pc_four, 32'h4);
    chk("rst_b_pc4", pc4_b, 32'h4);

    // reset fetch
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    wait_acc("rf_a0", 32'h100, 1, c0);
    chk("rf_first", 32'(c0 - r), 32'h1);
    wait_acc("rf_a1", 32'h104, 1, c1);
    wait_acc("rf_a2", 32'h108, 1, c2);
    chk("rf_gap1", 32'(c1 - c0), 32'h2);
    chk("rf_gap2", 32'(c2 - c1), 32'h2);
    wait_q_empty("rf_drain");

    // backpressure from a fresh reset
    @(posedge clk); #1;
    rst = 1'b1;
    instr_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    a0 = n_acc;
    repeat (12) @(negedge clk);
    chk("bp_nacc", 32'(n_acc - a0), 32'h2);
    chk("bp_req", 32'(mem_req), 32'h0);
    chk("bp_valid", 32'(instr_valid), 32'h1);
    chk("bp_pc", instr_pc, 32'h100);
    s = instr;
    repeat (3) @(negedge clk);
    chk("bp_stable", instr, s);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_acc("bp_resume", 32'h108, 1, c0);
    wait_q_empty("bp_drain");

    // grant stall
    @(posedge clk); #1;
    gnt_en = 1'b0;
    wait_sig("gs_req_seen", 1'b0);
    a = mem_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gs_req", 32'(mem_req), 32'h1);
      chk("gs_addr", mem_addr, a);
    end
    exp_q.push_back(a);
    exp_q.push_back(a + 32'd4);
    #1;
    gnt_en = 1'b1;
    wait_q_empty("gs_drain");

    // redirect while WAIT, stale rvalid three cycles after grant
    lat = 3;
    wait_acc("r1_pre", 32'h0, 0, c0);
    @(posedge clk); #1;
    redirect = 1'b1;
    rpc = 32'h2002;
    exp_q.delete();
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h2004);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("r1_valid", 32'(instr_valid), 32'h0);
    chk("r1_req", 32'(mem_req), 32'h0);
    wait_acc("r1_acc", 32'h2000, 1, c0);
    lat = 1;
    wait_q_empty("r1_drain");

    // redirect coincident with grant
    wait_sig("r2_req_seen", 1'b0);
    #1;
    redirect = 1'b1;
    rpc = 32'h3000;
    exp_q.delete();
    exp_q.push_back(32'h3000);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("r2_valid", 32'(instr_valid), 32'h0);
    chk("r2_req", 32'(mem_req), 32'h0);
    wait_acc("r2_acc", 32'h3000, 1, c0);
    wait_q_empty("r2_drain");

    // redirect coincident with rvalid
    wait_sig("r3_rv_seen", 1'b1);
    #1;
    redirect = 1'b1;
    rpc = 32'h4000;
    exp_q.delete();
    exp_q.push_back(32'h4000);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("r3_valid", 32'(instr_valid), 32'h0);
    chk("r3_req", 32'(mem_req), 32'h1);
    chk("r3_addr", mem_addr, 32'h4000);
    wait_q_empty("r3_drain");

    // flush with full FIFO and ready high
    @(posedge clk); #1;
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("fl_full_valid", 32'(instr_valid), 32'h1);
    chk("fl_full_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    redirect = 1'b1;
    rpc = 32'h5000;
    exp_q.delete();
    exp_q.push_back(32'h5000);
    exp_q.push_back(32'h5004);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(instr_valid), 32'h0);
    chk("fl_req", 32'(mem_req), 32'h1);
    chk("fl_addr", mem_addr, 32'h5000);
    wait_q_empty("fl_drain");

    // address wrap on the second instance
    @(posedge clk); #1;
    rst_b = 1'b0;
    nb = 0;
    ba1 = 32'h1;
    ba2 = 32'h1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_b) begin
        if (nb == 0) ba1 = addr_b;
        else if (nb == 1) ba2 = addr_b;
        nb++;
      end
    end
    chk("wr_a0", ba1, 32'hFFFF_FFFC);
    chk("wr_a1", ba2, 32'h0);
    chk("wr_valid", 32'(valid_b), 32'h1);
    chk("wr_pc", pc_b, 32'hFFFF_FFFC);
    chk("wr_pc4", pc4_b, 32'h0);
    chk("wr_instr", instr_b, mk(32'hFFFF_FFFC));

    // async reset mid-WAIT
    lat = 3;
    @(posedge clk); #1;
    redirect = 1'b1;
    rpc = 32'h6000;
    exp_q.delete();
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_acc("ar_acc", 32'h6000, 1, c0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req), 32'h0);
    chk("ar_addr", mem_addr, 32'h100);
    chk("ar_valid", 32'(instr_valid), 32'h0);
    chk("ar_instr", instr, 32'h0);
    chk("ar_pc", instr_pc, 32'h0);
    chk("ar_pc4", instr_pc_four, 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
